// File: rtl/binser_pkg.sv
// rtl/binser_pkg.sv - shared constants, state type and helpers for the binary-serial PE
package binser_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DEPTH_DEF     = 3;
    localparam int ACC_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

    function automatic int msb_idx(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/serial_term_shift.sv
// rtl/serial_term_shift.sv - weights one partial product by its bit index, negating the MSB term
module serial_term_shift
    import binser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic [DEPTH-1:0]            idx,
    input  logic signed [2*WIDTH-1:0]   pp,
    output logic signed [ACC_WIDTH-1:0] term
);

    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] shifted;

    assign ext     = ACC_WIDTH'(pp);
    assign shifted = ext << idx;

    // Multiplier MSB has weight -2^(WIDTH-1) in two's complement.
    assign term = (idx == DEPTH'(msb_idx(WIDTH))) ? -shifted : shifted;

endmodule

// File: rtl/mul_serial_acc.sv
// rtl/mul_serial_acc.sv - shift-add accumulator turning serial partial products into psum + a*b
module mul_serial_acc
    import binser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clr,
    input  logic [DEPTH-1:0]            i_idx,
    input  logic signed [2*WIDTH-1:0]   i_pp,
    input  logic signed [ACC_WIDTH-1:0] i_psum,
    output logic signed [ACC_WIDTH-1:0] o_psum,
    output logic                        o_valid,
    output logic                        o_busy,
    output logic                        o_err
);

    acc_state_t                  state, state_next;
    logic signed [ACC_WIDTH-1:0] acc, acc_next, psum_next, term;
    logic [DEPTH-1:0]            exp_idx, exp_next;
    logic                        err_next, valid_next, last;

    serial_term_shift #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_term (
        .idx (i_idx),
        .pp  (i_pp),
        .term(term)
    );

    assign last   = (i_idx == DEPTH'(msb_idx(WIDTH)));
    assign o_busy = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            exp_idx <= '0;
            o_psum  <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            exp_idx <= exp_next;
            o_psum  <= psum_next;
            o_valid <= valid_next;
            o_err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        exp_next   = exp_idx;
        psum_next  = o_psum;
        err_next   = o_err;
        valid_next = 1'b0;
        if (clr) begin
            state_next = IDLE;
            acc_next   = '0;
            exp_next   = '0;
            psum_next  = '0;
            err_next   = 1'b0;
        end else begin
            case (state)
                // DONE accepts a new idx-0 beat exactly like IDLE, giving back-to-back products.
                IDLE, DONE: begin
                    state_next = IDLE;
                    if (en) begin
                        if (i_idx == '0) begin
                            acc_next   = i_psum + term;
                            exp_next   = DEPTH'(1);
                            state_next = ACCUM;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (en) begin
                        if (i_idx == exp_idx) begin
                            acc_next = acc + term;
                            if (last) begin
                                state_next = DONE;
                                exp_next   = '0;
                                psum_next  = acc + term;
                                valid_next = 1'b1;
                            end else begin
                                exp_next = exp_idx + DEPTH'(1);
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_serial_acc.sv
// tb/tb_mul_serial_acc.sv - self-checking bench for mul_serial_acc against psum + a*b
module tb_mul_serial_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               clr;
    logic [2:0]         i_idx;
    logic signed [15:0] i_pp;
    logic signed [23:0] i_psum;
    logic signed [23:0] o_psum;
    logic               o_valid;
    logic               o_busy;
    logic               o_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int exp_pulses = 0;

    mul_serial_acc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .i_idx  (i_idx),
        .i_pp   (i_pp),
        .i_psum (i_psum),
        .o_psum (o_psum),
        .o_valid(o_valid),
        .o_busy (o_busy),
        .o_err  (o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_valid) n_pulses++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    function automatic logic [23:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [23:0] psum);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 24'(int'(psum) + p);
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [23:0] psum);
        en     = 1'b1;
        i_idx  = 3'(k);
        i_pp   = a[k] ? 16'($signed(b)) : 16'sd0;
        i_psum = (k == 0) ? psum : 24'($urandom);
        tick();
    endtask

    // Returns in the DONE cycle; a stall of stall_len idle cycles follows beat stall_after.
    task automatic run_product(input logic [7:0] a, input logic [7:0] b, input logic [23:0] psum,
                               input int stall_after, input int stall_len);
        for (int k = 0; k < 8; k++) begin
            beat(k, a, b, psum);
            if (k == 0) begin
                chk("start_busy", 24'(o_busy), 24'd1);
                chk("start_valid", 24'(o_valid), 24'd0);
            end
            if (k == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    en    = 1'b0;
                    i_idx = 3'($urandom);
                    i_pp  = 16'($urandom);
                    tick();
                    chk("stall_busy", 24'(o_busy), 24'd1);
                end
            end
        end
        en = 1'b0;
        exp_pulses++;
    endtask

    task automatic chk_done(input string tag, input logic [23:0] exp);
        chk({tag, "_valid"}, 24'(o_valid), 24'd1);
        chk({tag, "_psum"}, o_psum, exp);
        chk({tag, "_busy"}, 24'(o_busy), 24'd0);
    endtask

    task automatic chk_after(input string tag, input logic [23:0] exp);
        tick();
        chk({tag, "_pulse_end"}, 24'(o_valid), 24'd0);
        chk({tag, "_hold"}, o_psum, exp);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [23:0] rp, rexp;
        int          sa;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; i_idx = '0; i_pp = '0; i_psum = '0;
        repeat (3) tick();
        chk("rst_psum", o_psum, 24'd0);
        chk("rst_valid", 24'(o_valid), 24'd0);
        chk("rst_busy", 24'(o_busy), 24'd0);
        chk("rst_err", 24'(o_err), 24'd0);
        rst_n = 1'b1;
        tick();

        run_product(8'd3, 8'd5, 24'd100, -1, 0);
        chk_done("basic", 24'd115);
        chk("basic_err", 24'(o_err), 24'd0);
        chk_after("basic", 24'd115);

        run_product(8'hFF, 8'd5, 24'd0, -1, 0);
        chk_done("neg_mult", 24'hFFFFFB);
        chk_after("neg_mult", 24'hFFFFFB);
        run_product(8'h80, 8'h80, 24'd0, -1, 0);
        chk_done("min_min", 24'd16384);
        chk_after("min_min", 24'd16384);

        run_product(8'h5A, 8'hC3, 24'd1000, 3, 3);
        chk_done("stall", model(8'h5A, 8'hC3, 24'd1000));
        run_product(8'hA7, 8'h19, 24'hFFF000, -1, 0);
        chk_done("b2b", model(8'hA7, 8'h19, 24'hFFF000));
        chk_after("b2b", model(8'hA7, 8'h19, 24'hFFF000));

        beat(0, 8'h6D, 8'h2B, 24'd20);
        beat(1, 8'h6D, 8'h2B, 24'd20);
        beat(3, 8'h6D, 8'h2B, 24'd20);
        chk("seq_err", 24'(o_err), 24'd1);
        chk("seq_busy", 24'(o_busy), 24'd1);
        for (int k = 2; k < 8; k++) beat(k, 8'h6D, 8'h2B, 24'd20);
        en = 1'b0;
        exp_pulses++;
        chk_done("seq_resend", model(8'h6D, 8'h2B, 24'd20));
        chk("seq_err_sticky", 24'(o_err), 24'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err", 24'(o_err), 24'd0);
        chk("clr_psum", o_psum, 24'd0);

        for (int k = 0; k < 4; k++) beat(k, 8'h33, 8'h44, 24'd5);
        clr = 1'b1;
        beat(4, 8'h33, 8'h44, 24'd5);
        clr = 1'b0;
        en  = 1'b0;
        chk("clr_mid_busy", 24'(o_busy), 24'd0);
        chk("clr_mid_valid", 24'(o_valid), 24'd0);
        repeat (4) tick();
        chk("clr_mid_no_pulse", 24'(o_valid), 24'd0);
        run_product(8'd1, 8'd2, 24'd7, -1, 0);
        chk_done("after_clr", 24'd9);
        chk_after("after_clr", 24'd9);

        run_product(8'd1, 8'd1, 24'h7FFFFF, -1, 0);
        chk_done("wrap", 24'h800000);
        chk_after("wrap", 24'h800000);

        beat(3, 8'd0, 8'd0, 24'd0);
        en = 1'b0;
        chk("idle_err", 24'(o_err), 24'd1);
        chk("idle_err_busy", 24'(o_busy), 24'd0);
        for (int k = 0; k < 5; k++) beat(k, 8'h77, 8'h11, 24'd3);
        en = 1'b1; i_idx = 3'd5;
        #2 rst_n = 1'b0;
        #1;
        chk("async_psum", o_psum, 24'd0);
        chk("async_busy", 24'(o_busy), 24'd0);
        chk("async_err", 24'(o_err), 24'd0);
        chk("async_valid", 24'(o_valid), 24'd0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_product(8'h77, 8'h11, 24'd3, -1, 0);
        chk_done("after_rst", model(8'h77, 8'h11, 24'd3));

        for (int t = 0; t < 24; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 24'($urandom);
            sa = $urandom_range(0, 9);
            rexp = model(ra, rb, rp);
            run_product(ra, rb, rp, (sa > 6) ? -1 : sa, $urandom_range(1, 3));
            chk_done("rand", rexp);
            if ($urandom_range(0, 1) == 1) chk_after("rand", rexp);
        end
        tick();
        chk("pulse_count", 24'(n_pulses), 24'(exp_pulses));
        chk("final_err", 24'(o_err), 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
